sequence_detector_param: RTL and testbench

- Parametrised successor to the fixed-pattern single-bit Mealy detector.
- Serial bit-stream detector with a runtime-programmable pattern of length 1..MAX_LEN.
- Selectable overlapping or non-overlapping detection, and selectable Mealy or Moore output timing.
- Saturating match counter for monitoring.
- Sits between a serial front end and control logic that consumes single-cycle detect pulses.

---
 rtl/seqdet_pkg.sv | 27 ++
 rtl/seqdet_sat_counter.sv | 26 ++
 rtl/sequence_detector_param.sv | 129 ++++++++++++
 tb/tb_sequence_detector_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and helpers for the parametrised sequence detector.
//   seq_state_t : detector state (UNCFG, FILL, ARMED)
//   len_w()     : width of a length field able to hold 0..max_len
//   window_eq() : compares a received window against a pattern over the low
//                 'len' bits only; bits at positions >= len are ignored.
package seqdet_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } seq_state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Operands are zero-extended to 32 bits, the largest legal MAX_LEN.
    function automatic logic window_eq(input logic [31:0] win,
                                       input logic [31:0] pat,
                                       input logic [5:0]  len);
        logic [31:0] mask;
        mask = (len >= 6'd32) ? '1 : ((32'd1 << len) - 32'd1);
        return ((win ^ pat) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// seqdet_sat_counter: saturating up-counter.
//   clk, reset : clock and asynchronous active-low reset
//   inc        : count one event (ignored once at all-ones)
//   clr        : synchronous clear, wins over inc
//   count      : current value, holds at 2^CNT_W-1
module seqdet_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sequence_detector_param.sv
// sequence_detector_param: serial bit-stream pattern detector with a runtime
// programmable pattern (1..MAX_LEN bits), overlap / non-overlap detection,
// Mealy or Moore output timing and a saturating match counter.
//   clk, reset   : clock, asynchronous active-low reset
//   x, x_valid   : serial data bit and its qualifier
//   cfg_load     : one-cycle strobe capturing cfg_pattern/len/overlap/moore
//   cfg_pattern  : pattern, bit len-1 is received first, bit 0 last
//   cfg_len      : pattern length (0 = unconfigured, >MAX_LEN clamps)
//   cfg_overlap  : 1 = overlapping detection
//   cfg_moore    : 1 = registered output one cycle after the match edge
//   detector_out : one pulse per match
//   match_count  : saturating number of matches since reset / cfg_load
//   armed        : next valid bit can complete a match
module sequence_detector_param
    import seqdet_pkg::*;
#(
    parameter  int                 MAX_LEN         = 8,
    parameter  int                 CNT_W           = 16,
    parameter  logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter  int                 DEFAULT_LEN     = 4,
    localparam int                 LEN_W           = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    seq_state_t         state;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               moore;
    logic [MAX_LEN-2:0] history;    // LSB = newest bit
    logic [LEN_W-1:0]   fill_cnt;
    logic               moore_q;

    logic [MAX_LEN-1:0] window;
    logic [LEN_W-1:0]   len_clamped;
    logic               match;

    assign window      = {history, x};
    assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    // A load in the same cycle discards the incoming bit.
    assign match = x_valid && !cfg_load && (state == ARMED) &&
                   window_eq(32'(window), 32'(pattern), 6'(len));

    assign detector_out = cfg_load ? 1'b0 : (moore ? moore_q : match);
    assign armed        = (state == ARMED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern  <= DEFAULT_PATTERN;
            len      <= LEN_W'(DEFAULT_LEN);
            overlap  <= 1'b1;
            moore    <= 1'b0;
            history  <= '0;
            fill_cnt <= '0;
            moore_q  <= 1'b0;
            // A one-bit pattern needs no history, so it starts armed.
            state    <= (DEFAULT_LEN == 1) ? ARMED : FILL;
        end else if (cfg_load) begin
            pattern  <= cfg_pattern;
            len      <= len_clamped;
            overlap  <= cfg_overlap;
            moore    <= cfg_moore;
            history  <= '0;
            fill_cnt <= '0;
            moore_q  <= 1'b0;
            if (cfg_len == '0) begin
                state <= UNCFG;
            end else if (len_clamped == LEN_W'(1)) begin
                state <= ARMED;
            end else begin
                state <= FILL;
            end
        end else begin
            moore_q <= match;
            if (x_valid) begin
                case (state)
                    FILL: begin
                        history  <= window[MAX_LEN-2:0];
                        fill_cnt <= fill_cnt + LEN_W'(1);
                        if ((fill_cnt + LEN_W'(1)) == (len - LEN_W'(1))) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (match && !overlap) begin
                            // Non-overlapping: the matched window is consumed.
                            history  <= '0;
                            fill_cnt <= '0;
                            if (len != LEN_W'(1)) begin
                                state <= FILL;
                            end
                        end else begin
                            history <= window[MAX_LEN-2:0];
                            if (fill_cnt != LEN_W'(MAX_LEN - 1)) begin
                                fill_cnt <= fill_cnt + LEN_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    seqdet_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cfg_load),
        .count (match_count)
    );

endmodule

// File: tb/tb_sequence_detector_param.sv
module tb_sequence_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               armed;

    int compared   = 0;
    int mismatched = 0;

    sequence_detector_param #(
        .MAX_LEN         (MAX_LEN),
        .CNT_W           (CNT_W),
        .DEFAULT_PATTERN (8'b0000_1011),
        .DEFAULT_LEN     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .x_valid      (x_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .cfg_moore    (cfg_moore),
        .detector_out (detector_out),
        .match_count  (match_count),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge, then check detector_out.
    task automatic step(input logic xv, input logic b, input logic exp_det, input string tag);
        @(negedge clk);
        cfg_load = 1'b0;
        x_valid  = xv;
        x        = b;
        #1;
        chk(tag, 32'(detector_out), 32'(exp_det));
    endtask

    // Valid bits, bits[n-1] first; exp[i] is the expected detector_out for bits[i].
    task automatic stream(input logic [31:0] bits, input logic [31:0] exp,
                          input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], exp[i], tag);
        end
    endtask

    // Load a configuration with a competing valid bit present.
    task automatic cfg(input logic [7:0] pat, input logic [3:0] len,
                       input logic ov, input logic mo);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_moore   = mo;
        x_valid     = 1'b1;
        x           = 1'b1;
        #1;
        chk("cfg_cycle_det", 32'(detector_out), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_det", 32'(detector_out), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        x           = 1'b0;
        x_valid     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_moore   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_det", 32'(detector_out), 32'd0);
        chk("reset_cnt", 32'(match_count), 32'd0);
        chk("reset_armed", 32'(armed), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Defaults: 1011 len 4, overlap, Mealy.
        stream(32'b1011011, 32'b0001001, 7, "dflt_overlap");
        step(1'b0, 1'b1, 1'b0, "dflt_idle");
        chk("dflt_cnt", 32'(match_count), 32'd2);
        chk("dflt_armed", 32'(armed), 32'd1);

        // Non-overlapping.
        cfg(8'b0000_1011, 4'd4, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "novl_idle0");
        chk("novl_cnt_clr", 32'(match_count), 32'd0);
        chk("novl_armed0", 32'(armed), 32'd0);
        stream(32'b10110111, 32'b00010000, 8, "novl");
        step(1'b0, 1'b0, 1'b0, "novl_idle1");
        chk("novl_cnt1", 32'(match_count), 32'd1);
        stream(32'b1011, 32'b0001, 4, "novl_fresh");
        step(1'b0, 1'b0, 1'b0, "novl_idle2");
        chk("novl_cnt2", 32'(match_count), 32'd2);

        // Moore, pattern 11 len 2: output shows the previous bit's match.
        cfg(8'b0000_0011, 4'd2, 1'b1, 1'b1);
        stream(32'b1111, 32'b0011, 4, "moore");
        step(1'b0, 1'b0, 1'b1, "moore_tail1");
        step(1'b0, 1'b0, 1'b0, "moore_tail2");
        chk("moore_cnt", 32'(match_count), 32'd3);

        // x_valid gaps with x toggling while invalid.
        cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, "gap_b1");
        for (int g = 0; g < 3; g++) step(1'b0, g[0], 1'b0, "gap_inv1");
        step(1'b1, 1'b0, 1'b0, "gap_b2");
        for (int g = 0; g < 3; g++) step(1'b0, ~g[0], 1'b0, "gap_inv2");
        step(1'b1, 1'b1, 1'b0, "gap_b3");
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, "gap_inv3");
        step(1'b1, 1'b1, 1'b1, "gap_b4");
        step(1'b0, 1'b1, 1'b0, "gap_after");
        chk("gap_cnt", 32'(match_count), 32'd1);

        // Length 0: unconfigured.
        cfg(8'b0000_0000, 4'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, "uncfg_idle");
        chk("uncfg_armed", 32'(armed), 32'd0);
        stream(32'b00001011, 32'b0, 8, "uncfg");
        step(1'b0, 1'b0, 1'b0, "uncfg_idle2");
        chk("uncfg_cnt", 32'(match_count), 32'd0);
        chk("uncfg_armed2", 32'(armed), 32'd0);

        // Length 9 clamps to 8.
        cfg(8'b1010_0110, 4'd9, 1'b1, 1'b0);
        stream(32'b101001, 32'b0, 6, "clamp_fill");
        step(1'b0, 1'b0, 1'b0, "clamp_idle");
        chk("clamp_armed6", 32'(armed), 32'd0);
        stream(32'b1, 32'b0, 1, "clamp_b7");
        step(1'b0, 1'b0, 1'b0, "clamp_idle2");
        chk("clamp_armed7", 32'(armed), 32'd1);
        stream(32'b0, 32'b1, 1, "clamp_b8");
        step(1'b0, 1'b0, 1'b0, "clamp_idle3");
        chk("clamp_cnt", 32'(match_count), 32'd1);

        // Length 1, pattern 1.
        cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, "len1_idle");
        chk("len1_armed", 32'(armed), 32'd1);
        stream(32'b10110, 32'b10110, 5, "len1");
        step(1'b0, 1'b0, 1'b0, "len1_idle2");
        chk("len1_cnt", 32'(match_count), 32'd3);

        // Saturation: ten matches on a 3-bit counter.
        cfg(8'b0000_0001, 4'd1, 1'b0, 1'b0);
        stream(32'h3FF, 32'h3FF, 10, "sat");
        step(1'b0, 1'b0, 1'b0, "sat_idle");
        chk("sat_cnt", 32'(match_count), 32'd7);

        // Async reset while a len-1 match is being presented.
        @(negedge clk);
        x_valid = 1'b1;
        x       = 1'b1;
        #1;
        chk("pre_rst_det", 32'(detector_out), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_det", 32'(detector_out), 32'd0);
        chk("async_rst_cnt", 32'(match_count), 32'd0);
        #1 reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, "post_rst_idle");

        // Partial pattern straddling a reset must not match.
        stream(32'b10, 32'b00, 2, "straddle_pre");
        reset_pulse();
        stream(32'b111011, 32'b000001, 6, "straddle_post");
        step(1'b0, 1'b0, 1'b0, "straddle_idle");
        chk("straddle_cnt", 32'(match_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
